// File: rtl/gpi_input_conditioner.sv
// gpi_input_conditioner
// Multi-channel conditioner for pull-up general-purpose input pads.
// Each channel is synchronised into the core clock domain and debounced by a
// programmable glitch filter. The channel produces a clean level, a one-cycle
// qualified edge pulse and a sticky interrupt flag.
// Optional feature macro: GPI_COND_GLITCH_STAT_EN adds the sticky GLITCH_O
// rejected-pulse flags. When the macro is undefined, the port and its logic are absent.
module gpi_input_conditioner #(
    parameter int NCH         = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic                 CLK_I,
    input  logic                 RST_I,
    input  logic [NCH-1:0]       DI_I,
    input  logic [NCH-1:0]       IE_I,
    input  logic [CNT_W-1:0]     FILT_LEN_I,
    input  logic [2*NCH-1:0]     EDGE_MODE_I,
    input  logic [NCH-1:0]       IRQ_CLR_I,
    output logic [NCH-1:0]       DI_O,
    output logic [NCH-1:0]       EDGE_O,
    output logic [NCH-1:0]       IRQ_O,
    output logic                 IRQ_ANY_O
`ifdef GPI_COND_GLITCH_STAT_EN
    ,
    output logic [NCH-1:0]       GLITCH_O
`endif
);

    // Synchroniser chain; stage 0 samples the asynchronous pads.
    logic [NCH-1:0]   sync_r [SYNC_STAGES];
    logic [NCH-1:0]   sync_s;

    // Per-channel debounce counters and next-state values.
    logic [CNT_W-1:0] cnt_r    [NCH];
    logic [CNT_W-1:0] cnt_nx_s [NCH];
    logic [NCH-1:0]   level_nx_s;
    logic [NCH-1:0]   edge_nx_s;
    logic [NCH-1:0]   irq_nx_s;

    assign sync_s = sync_r[SYNC_STAGES-1];

    // Shift pad samples through the synchroniser; idle level is the pull-up high.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_r[k] <= {NCH{1'b1}};
            end
        end else begin
            sync_r[0] <= DI_I;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_r[k] <= sync_r[k-1];
            end
        end
    end

    // Debounce decision per channel: count mismatches, commit after N+1 of them.
    always_comb begin
        level_nx_s = DI_O;
        edge_nx_s  = {NCH{1'b0}};
        for (int i = 0; i < NCH; i++) begin
            cnt_nx_s[i] = {CNT_W{1'b0}};
            if (IE_I[i]) begin
                if (sync_s[i] == DI_O[i]) begin
                    cnt_nx_s[i] = {CNT_W{1'b0}};
                end else if (cnt_r[i] >= FILT_LEN_I) begin
                    // Filtered edge: new level is the synchronised value.
                    // Rising edges qualify on mode bit 0, falling on bit 1.
                    level_nx_s[i] = sync_s[i];
                    cnt_nx_s[i]   = {CNT_W{1'b0}};
                    if (sync_s[i]) begin
                        edge_nx_s[i] = EDGE_MODE_I[2*i];
                    end else begin
                        edge_nx_s[i] = EDGE_MODE_I[2*i+1];
                    end
                end else begin
                    cnt_nx_s[i] = cnt_r[i] + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end else begin
                // Frozen channel: no counting, level and edges held off.
                cnt_nx_s[i] = {CNT_W{1'b0}};
            end
        end
        // Set has priority over clear so a coincident edge is never lost.
        irq_nx_s = edge_nx_s | (IRQ_O & ~IRQ_CLR_I);
    end

    // Register filtered levels, edge pulses, interrupt flags and counters.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            DI_O   <= {NCH{1'b1}};
            EDGE_O <= {NCH{1'b0}};
            IRQ_O  <= {NCH{1'b0}};
            for (int i = 0; i < NCH; i++) begin
                cnt_r[i] <= {CNT_W{1'b0}};
            end
        end else begin
            DI_O   <= level_nx_s;
            EDGE_O <= edge_nx_s;
            IRQ_O  <= irq_nx_s;
            for (int i = 0; i < NCH; i++) begin
                cnt_r[i] <= cnt_nx_s[i];
            end
        end
    end

    assign IRQ_ANY_O = |IRQ_O;

`ifdef GPI_COND_GLITCH_STAT_EN
    logic [NCH-1:0] glitch_set_s;

    // Detect an abandoned partial count: input returned to the filtered level.
    always_comb begin
        glitch_set_s = {NCH{1'b0}};
        for (int i = 0; i < NCH; i++) begin
            if (IE_I[i] && (sync_s[i] == DI_O[i]) && (cnt_r[i] != {CNT_W{1'b0}})) begin
                glitch_set_s[i] = 1'b1;
            end else begin
                glitch_set_s[i] = 1'b0;
            end
        end
    end

    // Sticky rejected-glitch flags, cleared with the interrupt clear; set wins.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            GLITCH_O <= {NCH{1'b0}};
        end else begin
            GLITCH_O <= glitch_set_s | (GLITCH_O & ~IRQ_CLR_I);
        end
    end
`endif

endmodule

// File: tb/tb_gpi_input_conditioner.sv
// Testbench for gpi_input_conditioner: directed scenarios followed by random
// stimulus, scored against a window-based behavioural model.
module tb_gpi_input_conditioner;

    localparam int NCH = 4;
    localparam int CW  = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NCH-1:0]  di = 4'hF;
    logic [NCH-1:0]  ie = 4'hF;
    logic [CW-1:0]   filt = 8'd3;
    logic [2*NCH-1:0] mode = 8'b11_10_11_10;
    logic [NCH-1:0]  clr = 4'h0;
    logic [NCH-1:0]  di_o, edge_o, irq_o;
    logic            irq_any_o;
`ifdef GPI_COND_GLITCH_STAT_EN
    logic [NCH-1:0]  glitch_o;
`endif

    gpi_input_conditioner #(.NCH(NCH), .SYNC_STAGES(2), .CNT_W(CW)) dut (
        .CLK_I(clk), .RST_I(rst), .DI_I(di), .IE_I(ie), .FILT_LEN_I(filt),
        .EDGE_MODE_I(mode), .IRQ_CLR_I(clr), .DI_O(di_o), .EDGE_O(edge_o),
        .IRQ_O(irq_o), .IRQ_ANY_O(irq_any_o)
`ifdef GPI_COND_GLITCH_STAT_EN
        , .GLITCH_O(glitch_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NCH-1:0] lvl;
        logic [NCH-1:0] edg;
        logic [NCH-1:0] irq;
        logic [NCH-1:0] gl;
        logic           any;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;

    // Reference model: a level flips when the last N+1 enabled samples of the
    // synchronised input all differ from it.
    bit [NCH-1:0] m_sync0, m_sync1, m_level, m_edge, m_irq, m_glitch, m_prevcnt;
    bit [15:0]    hs  [NCH];
    bit [15:0]    hie [NCH];
    int           hv  [NCH];

    function automatic exp_t model_exp();
        exp_t e;
        e.lvl = m_level; e.edg = m_edge; e.irq = m_irq; e.gl = m_glitch;
        e.any = |m_irq;
        return e;
    endfunction

    task automatic model_reset();
        m_sync0 = 4'hF; m_sync1 = 4'hF; m_level = 4'hF;
        m_edge = 4'h0; m_irq = 4'h0; m_glitch = 4'h0; m_prevcnt = 4'h0;
        for (int i = 0; i < NCH; i++) begin
            hs[i] = 16'h0; hie[i] = 16'h0; hv[i] = 0;
        end
    endtask

    task automatic model_step();
        int n;
        bit fire, s, lvl, gset;
        if (rst) begin
            model_reset();
            return;
        end
        n = int'(filt);
        for (int i = 0; i < NCH; i++) begin
            s   = m_sync1[i];
            lvl = m_level[i];
            hs[i]  = {hs[i][14:0], s};
            hie[i] = {hie[i][14:0], ie[i]};
            if (hv[i] < 16) hv[i]++;
            fire = (hv[i] > n);
            for (int k = 0; k <= n; k++) begin
                if (!(hie[i][k] && (hs[i][k] != lvl))) fire = 1'b0;
            end
            gset = ie[i] && (s == lvl) && m_prevcnt[i];
            m_prevcnt[i] = ie[i] && (s != lvl) && !fire;
            m_edge[i] = fire && (s ? mode[2*i] : mode[2*i+1]);
            if (fire) m_level[i] = s;
            m_irq[i]    = m_edge[i] | (m_irq[i] & ~clr[i]);
            m_glitch[i] = gset | (m_glitch[i] & ~clr[i]);
        end
        m_sync1 = m_sync0;
        m_sync0 = di;
    endtask

    // One clock: advance the model at the edge, then queue the expected outputs.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        exp_q.push_back(model_exp());
    endtask

    task automatic ticks(input int n);
        for (int j = 0; j < n; j++) tick();
    endtask

    // Mid-cycle asynchronous reset: the pending expectation becomes the reset state.
    task automatic async_reset();
        rst = 1'b1;
        model_reset();
        if (exp_q.size() > 0) exp_q[exp_q.size()-1] = model_exp();
    endtask

    task automatic chk(input string name, input logic [NCH-1:0] act, input logic [NCH-1:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        else passes++;
    endtask

    // Monitor: each cycle the DUT presents outputs, pop and compare.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("di_o", di_o, e.lvl);
                chk("edge_o", edge_o, e.edg);
                chk("irq_o", irq_o, e.irq);
                chk("irq_any_o", {3'b000, irq_any_o}, {3'b000, e.any});
`ifdef GPI_COND_GLITCH_STAT_EN
                chk("glitch_o", glitch_o, e.gl);
`endif
            end
        end
    end

    initial begin
        int r;
        model_reset();
        // Reset state
        ticks(3);
        rst = 1'b0;
        ticks(2);
        // Falling edge on ch0 (mode 10), then clear, then an unqualified rising edge
        di[0] = 1'b0; ticks(10);
        clr[0] = 1'b1; tick(); clr[0] = 1'b0; ticks(2);
        di[0] = 1'b1; ticks(8);
        // Pulse-width threshold on ch1: 3-cycle rejected, 4-cycle accepted
        di[1] = 1'b0; ticks(3); di[1] = 1'b1; ticks(8);
        di[1] = 1'b0; ticks(4); di[1] = 1'b1; ticks(10);
        // Channel freeze on ch2 two cycles into a count
        di[2] = 1'b0; ticks(4);
        ie[2] = 1'b0; ticks(6);
        ie[2] = 1'b1; ticks(8);
        di[2] = 1'b1; ticks(10);
        // Set beats clear on ch3
        di[3] = 1'b0; ticks(5);
        clr[3] = 1'b1; tick(); clr[3] = 1'b0; ticks(3);
        clr = 4'hF; tick(); clr = 4'h0;
        di[3] = 1'b1; ticks(8);
        // Reset mid-count on ch0
        di[0] = 1'b0; ticks(4);
        async_reset(); ticks(2);
        rst = 1'b0; ticks(10);
        di[0] = 1'b1; ticks(10);
        // Random phase
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < NCH; i++) begin
                if ($urandom_range(0, 5) == 0) di[i] = ~di[i];
                ie[i]  = ($urandom_range(0, 9) != 0);
                clr[i] = ($urandom_range(0, 7) == 0);
            end
            if ($urandom_range(0, 39) == 0) mode = 8'($urandom);
            if ($urandom_range(0, 59) == 0) filt = 8'($urandom_range(0, 7));
            r = int'($urandom_range(0, 299));
            if (r == 0) async_reset();
            else if (rst) rst = 1'b0;
            tick();
        end
        rst = 1'b0;
        ticks(3);
        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", 4'(exp_q.size()), 4'h0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/gpi_input_conditioner.md
# gpi_input_conditioner

Multi-channel conditioner for general-purpose input pads. Takes the raw receiver outputs of NCH pull-up input pads, synchronises them into the core clock domain, and debounces them with a programmable glitch filter. It produces clean per-channel levels, one-cycle edge pulses and sticky per-channel interrupt flags. It sits between the pad ring and core GPIO/interrupt logic, and replaces direct use of the pad DI output.

## Interface
- NCH, 8: number of input channels.
- SYNC_STAGES, 2: synchroniser flops per channel; minimum 2.
- CNT_W, 8: width of the debounce counter and of FILT_LEN_I.

- CLK_I  input  1  core clock
- RST_I  input  1  reset; asynchronous, active-high
- DI_I  input  NCH  raw pad receiver outputs; asynchronous to CLK_I
- IE_I  input  NCH  per-channel enable; 0 freezes the channel
- FILT_LEN_I  input  CNT_W  debounce length N, shared by all channels; quasi-static
- EDGE_MODE_I  input  2*NCH  per channel {b1,b0}: 00 none, 01 rising, 10 falling, 11 both
- IRQ_CLR_I  input  NCH  per-channel clear of IRQ_O, level-sensitive
- DI_O  output  NCH  filtered level
- EDGE_O  output  NCH  one-cycle pulse on each qualified filtered edge
- IRQ_O  output  NCH  sticky pending flag
- IRQ_ANY_O  output  1  OR of IRQ_O
- GLITCH_O  output  NCH  sticky rejected-glitch flag; present only with GPI_COND_GLITCH_STAT_EN

## Operation
Reset values:
- Synchroniser flops and DI_O: all 1, the pull-up idle level.
- Counters, EDGE_O, IRQ_O, GLITCH_O: all 0.
- IRQ_ANY_O: 0.

Each channel has a SYNC_STAGES-deep flop chain sampling DI_I. The last stage is s.

Debounce, evaluated per channel each cycle when IE_I=1:
- If s == DI_O: cnt <= 0.
- If s != DI_O and cnt >= FILT_LEN_I: DI_O <= s and cnt <= 0. This is a filtered edge.
- If s != DI_O otherwise: cnt <= cnt+1. The counter cannot overflow because the update fires at cnt >= FILT_LEN_I.

Pulse acceptance: a pulse on s is accepted only if it lasts at least N+1 consecutive cycles. Shorter pulses are rejected.

FILT_LEN_I may change at any time. The ">=" comparison guarantees that a lowered N takes effect on the next cycle.

When IE_I=0:
- The sync chain keeps sampling.
- cnt is held at 0.
- DI_O holds its value.
- No edges are generated.
- Re-enabling resumes normal filtering. If s differs from DI_O at that point, that mismatch counts as a fresh edge.

Edge qualification:
- Rising = DI_O 0->1; falling = DI_O 1->0.
- EDGE_O[i] is registered and goes high in the same cycle DI_O[i] first shows the new value, for exactly 1 cycle.
- A filtered edge produces an EDGE_O pulse only if it matches EDGE_MODE_I[2i+1:2i].

IRQ behaviour:
- IRQ_O[i] is set by EDGE_O[i] and cleared by IRQ_CLR_I[i].
- If set and clear occur in the same cycle, set wins.
- IRQ_ANY_O is combinational from the IRQ_O registers.

## Timing
- Latency from a DI_I change (meeting setup before edge 0) to DI_O and EDGE_O: SYNC_STAGES + N + 1 cycles.
  - With defaults and N=0, this is 3 cycles.
- IRQ_O rises in the same cycle as EDGE_O.
- IRQ_CLR_I takes effect at the next clock edge.
- Each channel is independent. Simultaneous edges on several channels all register.
- When RST_I asserts mid-count, all state returns to reset values immediately (asynchronously). Deassertion must be synchronous to CLK_I; this is the integrator's responsibility.
- EDGE_MODE_I changes take effect on the next filtered edge. Pending IRQ_O flags are not affected.

## Configuration
- GPI_COND_GLITCH_STAT_EN defined:
  - Adds the GLITCH_O port.
  - GLITCH_O[i] sets when cnt>0, s == DI_O and IE_I[i]=1, i.e. a pulse was rejected.
  - GLITCH_O[i] is cleared by IRQ_CLR_I[i]; if set and clear occur in the same cycle, set wins.
  - GLITCH_O does not contribute to IRQ_ANY_O.
- Not defined: the port and its logic are absent. All other behaviour is identical.

## Test plan
Bench settings: NCH=4, SYNC_STAGES=2, FILT_LEN_I=3, IE_I=4'hF.

1. Reset value: assert RST_I, then release -> DI_O=4'hF, EDGE_O=0, IRQ_O=0, IRQ_ANY_O=0.
2. Falling edge with mode 10 on ch0: drive DI_I[0] 1->0 and hold 10 cycles -> DI_O[0] falls 6 cycles after the change. EDGE_O[0] pulses for 1 cycle in that same cycle. IRQ_O[0]=1 and IRQ_ANY_O=1 until IRQ_CLR_I[0]; IRQ_O[0]=0 one cycle after the clear.
3. Pulse-width threshold on ch1: a 3-cycle low pulse -> DI_O[1] stays 1, no EDGE_O, GLITCH_O[1]=1 when the macro is defined. A 4-cycle low pulse -> DI_O[1] low for 4 cycles, with edges per EDGE_MODE.
4. Channel freeze on ch2: drop IE_I[2] two cycles into a count -> DI_O[2] holds and no edge occurs. Re-enable with DI_I[2] still low -> DI_O[2] falls N+1=4 cycles later.
5. Set beats clear on ch3: a filtered edge on ch3 coincides with IRQ_CLR_I[3]=1 -> IRQ_O[3]=1 afterwards.
6. Reset mid-count: assert RST_I 2 cycles into a ch0 count -> DI_O[0]=1 and cnt=0 immediately. After release, a low pulse needs the full 4 cycles to be accepted.
